shift_arbiter_2r: RTL and testbench
===================================

SHIFT_ARBITER_2R -- requirements
Module: shift_arbiter_2r

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock; rst  input  1  synchronous active-high reset.
REQ-002 req0_valid  input  1  requester 0 has an operation pending.
REQ-003 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-004 req0_in / req0_op / req0_shift  input  16 / 2 / 4  requester 0 operand, op code and shift amount.
REQ-005 req1_valid, req1_ready, req1_in, req1_op, req1_shift SHALL mirror REQ-002..REQ-004 for requester 1.
REQ-006 rsp_valid  output  1  result register holds an unconsumed result.
REQ-007 rsp_ready  input  1  consumer takes the result this cycle.
REQ-008 rsp_id  output  1  requester that owns the current result.
REQ-009 rsp_data  output  16  shifted result.
REQ-010 busy  output  1  high whenever state is not IDLE.

Function
REQ-011 The block SHALL instantiate exactly one shifter_16b and share it between both requesters.
REQ-012 Op encoding SHALL be: 00 shift left logical, 01 shift right logical, 10 rotate left, 11 rotate right; shift amount 0..15; amount 0 returns the operand unchanged.
REQ-013 The FSM SHALL have the states IDLE, EXEC and RESP.
REQ-014 IDLE: when either valid is high, grant one requester, assert its ready (combinationally, this cycle only), latch in/op/shift and the grant id into operand registers at the edge, and go to EXEC.
REQ-015 Arbitration SHALL be round-robin: when only one valid is high, that requester wins; when both are high, the requester not granted last wins; last_grant SHALL update on every accept.
REQ-016 At most one ready SHALL be high in any cycle; both readys SHALL be low outside IDLE.
REQ-017 EXEC: the shifter output from the operand registers is loaded into rsp_data, rsp_id is loaded from the latched grant id, rsp_valid is set, and the FSM goes to RESP unconditionally (one cycle).
REQ-018 RESP: rsp_valid, rsp_id and rsp_data SHALL hold stable until rsp_valid && rsp_ready; on that edge rsp_valid clears and the FSM goes to IDLE.
REQ-019 Latency: accept at edge k SHALL give rsp_valid high after edge k+1; minimum issue interval 3 cycles (accept, EXEC, RESP with rsp_ready high).
REQ-020 A request arriving while not in IDLE SHALL wait (ready low) and SHALL NOT be dropped or reordered per requester.
REQ-021 Operand registers SHALL load only on an accept; requester inputs that change after acceptance SHALL NOT affect the result.
REQ-022 rsp_ready while rsp_valid is low SHALL be ignored.

Reset
REQ-023 Reset SHALL force state IDLE, rsp_valid 0, rsp_id 0, rsp_data 0x0000, busy 0, operand registers 0, last_grant 1 (requester 0 wins the first tie).
REQ-024 Reset in EXEC or RESP SHALL discard the in-flight operation; no rsp_valid SHALL be produced for it.
REQ-025 Reset SHALL override any simultaneous accept or response handshake in the same cycle.

Verification
REQ-026 Single op: req0 {in=0x8001, op=00, shift=1}, rsp_ready=1 -> req0_ready for 1 cycle, rsp_valid after 2 edges, rsp_data=0x0002, rsp_id=0.
REQ-027 Op coverage: req1 {0x0001,11,1} -> 0x8000; {0x8000,01,15} -> 0x0001; {0x1234,10,4} -> 0x2341; {0xBEEF,10,0} -> 0xBEEF; rsp_id=1 each.
REQ-028 Tie/fairness: both valid continuously from reset, 4 ops each, rsp_ready=1 -> grant order 0,1,0,1,...; all 8 results correct; never both readys high.
REQ-029 Backpressure: result pending, rsp_ready=0 for 5 cycles -> rsp_valid/rsp_data/rsp_id stable, both readys 0, busy 1; rsp_ready=1 -> IDLE the next cycle, then the next request is accepted.
REQ-030 Reset mid-op: assert rst in EXEC, then in RESP -> next cycle rsp_valid=0, busy=0, rsp_data=0x0000; the next tie grants requester 0.
REQ-031 Operand isolation: change req0_in from 0x00FF to 0xFFFF the cycle after accept with {op=00, shift=8} -> rsp_data=0xFF00.

Source files
------------

// File: rtl/shift_arbiter_2r.sv
// Two-requester round-robin front end sharing a single 16-bit shifter.
// Accept (IDLE) -> compute (EXEC) -> hold result until consumed (RESP).

module shifter_16b #(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] data_in,
    input  logic [1:0]        op,
    input  logic [3:0]        shamt,
    output logic [DATA_W-1:0] data_out
);
    // Rotates shift a doubled copy of the operand and keep the wrapped half.
    function automatic logic [DATA_W-1:0] shift_fn(input logic [DATA_W-1:0] x,
                                                   input logic [1:0]        code,
                                                   input logic [3:0]        s);
        logic [2*DATA_W-1:0] dbl;
        logic [DATA_W-1:0]   r;
        dbl = {x, x};
        r   = x;
        case (code)
            2'b00: r = x << s;
            2'b01: r = x >> s;
            2'b10: begin
                dbl = dbl << s;
                r   = dbl[2*DATA_W-1:DATA_W];
            end
            default: begin
                dbl = dbl >> s;
                r   = dbl[DATA_W-1:0];
            end
        endcase
        return r;
    endfunction

    assign data_out = shift_fn(data_in, op, shamt);
endmodule

module shift_arbiter_2r #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_in,
    input  logic [1:0]        req0_op,
    input  logic [3:0]        req0_shift,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_in,
    input  logic [1:0]        req1_op,
    input  logic [3:0]        req1_shift,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            state, state_nxt;
    logic              last_grant;
    logic              gnt_id;
    logic              accept;
    logic [DATA_W-1:0] opnd_in_p0;
    logic [1:0]        opnd_op_p0;
    logic [3:0]        opnd_shift_p0;
    logic              opnd_id_p0;
    logic [DATA_W-1:0] shift_out;

    shifter_16b #(.DATA_W(DATA_W)) u_shifter (
        .data_in  (opnd_in_p0),
        .op       (opnd_op_p0),
        .shamt    (opnd_shift_p0),
        .data_out (shift_out)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req0_valid || req1_valid) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // On a tie the requester that did not win last time gets the grant.
    always_comb begin
        gnt_id     = 1'b0;
        accept     = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        busy       = (state != IDLE);
        if (state == IDLE) begin
            if (req0_valid && req1_valid) gnt_id = ~last_grant;
            else                          gnt_id = req1_valid;
            accept     = req0_valid || req1_valid;
            req0_ready = accept && !gnt_id;
            req1_ready = accept && gnt_id;
        end
    end

    // Stage p0: operands captured on accept only
    always_ff @(posedge clk) begin
        if (rst) begin
            opnd_in_p0    <= '0;
            opnd_op_p0    <= '0;
            opnd_shift_p0 <= '0;
            opnd_id_p0    <= 1'b0;
            last_grant    <= 1'b1;
        end else if (accept) begin
            opnd_in_p0    <= gnt_id ? req1_in    : req0_in;
            opnd_op_p0    <= gnt_id ? req1_op    : req0_op;
            opnd_shift_p0 <= gnt_id ? req1_shift : req0_shift;
            opnd_id_p0    <= gnt_id;
            last_grant    <= gnt_id;
        end
    end

    // Stage p1: result register, held until the consumer takes it
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
        end else if (state == EXEC) begin
            rsp_valid <= 1'b1;
            rsp_id    <= opnd_id_p0;
            rsp_data  <= shift_out;
        end else if (state == RESP && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_shift_arbiter_2r.sv
// Directed bench for shift_arbiter_2r: ops, round-robin ties, backpressure,
// reset during an operation and operand isolation.

module tb_shift_arbiter_2r;
    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready;
    logic [15:0] req0_in;
    logic [1:0]  req0_op;
    logic [3:0]  req0_shift;
    logic        req1_valid, req1_ready;
    logic [15:0] req1_in;
    logic [1:0]  req1_op;
    logic [3:0]  req1_shift;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [15:0] rsp_data;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    shift_arbiter_2r dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_in(req0_in),
        .req0_op(req0_op), .req0_shift(req0_shift),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_in(req1_in),
        .req1_op(req1_op), .req1_shift(req1_shift),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Starts at a negedge with the FSM idle and rsp_ready high.
    task automatic run_op(input string tag, input bit id, input logic [15:0] din,
                          input logic [1:0] op, input logic [3:0] sh, input logic [15:0] exp);
        if (id) begin
            req1_in = din; req1_op = op; req1_shift = sh; req1_valid = 1'b1;
        end else begin
            req0_in = din; req0_op = op; req0_shift = sh; req0_valid = 1'b1;
        end
        #1;
        check({tag, "_ready"}, id ? req1_ready : req0_ready, 1);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        check({tag, "_exec_vld"}, rsp_valid, 0);
        check({tag, "_exec_rdy"}, {req0_ready, req1_ready}, 0);
        @(negedge clk);
        check({tag, "_vld"}, rsp_valid, 1);
        check({tag, "_data"}, rsp_data, exp);
        check({tag, "_id"}, rsp_id, id);
        @(negedge clk);
        check({tag, "_idle"}, {rsp_valid, busy}, 0);
    endtask

    logic [15:0] t0_in[4]  = '{16'h0001, 16'h00F0, 16'h8001, 16'h0003};
    logic [1:0]  t0_op[4]  = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic [3:0]  t0_sh[4]  = '{4'd1, 4'd4, 4'd1, 4'd1};
    logic [15:0] t0_exp[4] = '{16'h0002, 16'h000F, 16'h0003, 16'h8001};
    logic [15:0] t1_in[4]  = '{16'h1234, 16'h1234, 16'hFFFF, 16'hFFFF};
    logic [1:0]  t1_op[4]  = '{2'b10, 2'b11, 2'b00, 2'b01};
    logic [3:0]  t1_sh[4]  = '{4'd4, 4'd4, 4'd15, 4'd15};
    logic [15:0] t1_exp[4] = '{16'h2341, 16'h4123, 16'h8000, 16'h0001};

    initial begin
        logic [15:0] exp_q[$];
        logic        id_q[$];
        int i0, i1, ngr, nres;
        logic both_hi;

        rst = 1'b1; rsp_ready = 1'b1;
        req0_valid = 1'b0; req0_in = '0; req0_op = '0; req0_shift = '0;
        req1_valid = 1'b0; req1_in = '0; req1_op = '0; req1_shift = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_data", rsp_data, 16'h0000);
        check("rst_busy", busy, 0);
        check("rst_readys", {req0_ready, req1_ready}, 0);
        @(negedge clk);

        run_op("single", 1'b0, 16'h8001, 2'b00, 4'd1, 16'h0002);
        run_op("rotr1", 1'b1, 16'h0001, 2'b11, 4'd1, 16'h8000);
        run_op("srl15", 1'b1, 16'h8000, 2'b01, 4'd15, 16'h0001);
        run_op("rotl4", 1'b1, 16'h1234, 2'b10, 4'd4, 16'h2341);
        run_op("rotl0", 1'b1, 16'hBEEF, 2'b10, 4'd0, 16'hBEEF);

        // Tie / fairness: both valid from reset
        rst = 1'b1;
        i0 = 0; i1 = 0; ngr = 0; nres = 0; both_hi = 1'b0;
        req0_in = t0_in[0]; req0_op = t0_op[0]; req0_shift = t0_sh[0]; req0_valid = 1'b1;
        req1_in = t1_in[0]; req1_op = t1_op[0]; req1_shift = t1_sh[0]; req1_valid = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int cyc = 0; cyc < 60 && nres < 8; cyc++) begin
            logic adv0, adv1;
            if (cyc != 0) @(negedge clk);
            if (req0_ready && req1_ready) both_hi = 1'b1;
            adv0 = req0_ready; adv1 = req1_ready;
            if (adv0 || adv1) begin
                check("tie_order", adv1, ngr % 2);
                id_q.push_back(adv1);
                exp_q.push_back(adv1 ? t1_exp[i1] : t0_exp[i0]);
                ngr++;
            end
            if (rsp_valid && exp_q.size() > 0) begin
                check("tie_data", rsp_data, exp_q.pop_front());
                check("tie_id", rsp_id, id_q.pop_front());
                nres++;
            end
            @(posedge clk); #1;
            if (adv0) begin
                i0++;
                if (i0 < 4) begin
                    req0_in = t0_in[i0]; req0_op = t0_op[i0]; req0_shift = t0_sh[i0];
                end else req0_valid = 1'b0;
            end
            if (adv1) begin
                i1++;
                if (i1 < 4) begin
                    req1_in = t1_in[i1]; req1_op = t1_op[i1]; req1_shift = t1_sh[i1];
                end else req1_valid = 1'b0;
            end
        end
        check("tie_count", nres, 8);
        check("tie_excl", both_hi, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (3) @(negedge clk);

        // Backpressure
        rsp_ready = 1'b0;
        req1_in = 16'h00F0; req1_op = 2'b00; req1_shift = 4'd4; req1_valid = 1'b1;
        @(posedge clk); #1;
        req1_valid = 1'b0;
        req0_in = 16'h0001; req0_op = 2'b00; req0_shift = 4'd3; req0_valid = 1'b1;
        @(negedge clk);
        check("bp_exec_rdy", req0_ready, 0);
        @(negedge clk);
        check("bp_vld", rsp_valid, 1);
        check("bp_data", rsp_data, 16'h0F00);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_hold_vld", rsp_valid, 1);
            check("bp_hold_data", rsp_data, 16'h0F00);
            check("bp_hold_id", rsp_id, 1);
            check("bp_hold_busy", busy, 1);
            check("bp_hold_rdy", {req0_ready, req1_ready}, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_idle", {rsp_valid, busy}, 0);
        check("bp_next_rdy", req0_ready, 1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("bp_next_vld", rsp_valid, 1);
        check("bp_next_data", rsp_data, 16'h0008);
        check("bp_next_id", rsp_id, 0);
        @(negedge clk);

        // Reset in EXEC
        req0_in = 16'h0F0F; req0_op = 2'b00; req0_shift = 4'd4; req0_valid = 1'b1;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rexec_vld", rsp_valid, 0);
        check("rexec_busy", busy, 0);
        check("rexec_data", rsp_data, 16'h0000);
        @(negedge clk);
        check("rexec_no_rsp", rsp_valid, 0);

        // Reset in RESP; without the reset last_grant would favour requester 1
        rsp_ready = 1'b0;
        req0_valid = 1'b1;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rresp_pre_vld", rsp_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rresp_vld", rsp_valid, 0);
        check("rresp_busy", busy, 0);
        check("rresp_data", rsp_data, 16'h0000);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check("rresp_tie", {req0_ready, req1_ready}, 2'b10);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        repeat (3) @(negedge clk);

        // Operand isolation
        req0_in = 16'h00FF; req0_op = 2'b00; req0_shift = 4'd8; req0_valid = 1'b1;
        @(posedge clk); #1;
        req0_valid = 1'b0; req0_in = 16'hFFFF;
        @(negedge clk);
        @(negedge clk);
        check("iso_vld", rsp_valid, 1);
        check("iso_data", rsp_data, 16'hFF00);
        check("iso_id", rsp_id, 0);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
